dmem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory (256 x 32-bit words, synchronous read, write when `write_en` is high).
- Requester 0 is the core load/store path; requester 1 is the DMA/debug loader.
- Grants one request at a time with round-robin fairness, drives the memory command registers, and returns read data or write acknowledgement per requester with a fixed latency.
- Rejects misaligned or out-of-range accesses without touching memory.

---
 rtl/dmem_port_arbiter_pkg.sv | 23 ++
 rtl/dmem_port_arbiter_if.sv | 24 ++
 rtl/dmem_port_arbiter_rr_arbiter2.sv | 21 ++
 rtl/dmem_port_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_pkg;

  localparam int DMEM_DEPTH  = 256;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester's command/response channel into the data-memory arbiter.
interface dmem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time goes.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |valid;
    gnt_id    = REQ_CORE;
    if (&valid) begin
      gnt_id = ~last_grant;
    end else if (valid[1]) begin
      gnt_id = REQ_DMA;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates two requesters onto a single-port synchronous data memory,
// one transaction at a time: accept, issue command, return response.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_port_arbiter_if.slave  req0,
  dmem_port_arbiter_if.slave  req1,
  output logic                mem_write_en,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out,
  output logic                busy
);

  state_e    state, state_nxt;
  logic      last_grant;
  logic      gnt_valid, gnt_id;
  logic      accept;
  dmem_req_t sel_req;
  logic      sel_err;
  logic      gnt_p0, we_p0, err_p0;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
  endfunction

  rr_arbiter2 u_arb (
    .valid      ({req1.valid, req0.valid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    sel_req.we    = req0.we;
    sel_req.addr  = req0.addr;
    sel_req.wdata = req0.wdata;
    if (gnt_id == REQ_DMA) begin
      sel_req.we    = req1.we;
      sel_req.addr  = req1.addr;
      sel_req.wdata = req1.wdata;
    end
  end

  assign sel_err = addr_err(sel_req.addr);
  // Readies are combinational, so gate with rst_n to keep them low during reset.
  assign accept  = (state == IDLE) && gnt_valid && rst_n;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req0.ready = 1'b0;
    req1.ready = 1'b0;
    case (state)
      IDLE: begin
        req0.ready = accept && (gnt_id == REQ_CORE);
        req1.ready = accept && (gnt_id == REQ_DMA);
        if (accept) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0.rsp_valid = 1'b0;
    req1.rsp_valid = 1'b0;
    req0.rsp_rdata = '0;
    req1.rsp_rdata = '0;
    req0.rsp_err   = 1'b0;
    req1.rsp_err   = 1'b0;
    if (state == RESP) begin
      if (gnt_p0 == REQ_DMA) begin
        req1.rsp_valid = 1'b1;
        req1.rsp_rdata = (!we_p0 && !err_p0) ? mem_data_out : '0;
        req1.rsp_err   = err_p0;
      end else begin
        req0.rsp_valid = 1'b1;
        req0.rsp_rdata = (!we_p0 && !err_p0) ? mem_data_out : '0;
        req0.rsp_err   = err_p0;
      end
    end
  end

  // Handshake -> ISSUE: the memory command registers double as the address/data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= REQ_DMA;
      gnt_p0       <= REQ_CORE;
      we_p0        <= 1'b0;
      err_p0       <= 1'b0;
      mem_write_en <= 1'b0;
      mem_address  <= '0;
      mem_data_in  <= '0;
    end else begin
      state        <= state_nxt;
      mem_write_en <= 1'b0;
      if (accept) begin
        gnt_p0       <= gnt_id;
        last_grant   <= gnt_id;
        we_p0        <= sel_req.we;
        err_p0       <= sel_err;
        mem_address  <= sel_req.addr;
        mem_data_in  <= sel_req.wdata;
        mem_write_en <= sel_req.we && !sel_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural memory and transaction model.
module tb_dmem_port_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        busy;

  always #5 clk = ~clk;

  dmem_port_arbiter_if req0_if ();
  dmem_port_arbiter_if req1_if ();

  dmem_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0_if),
    .req1         (req1_if),
    .mem_write_en (mem_write_en),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 32) return 32'hDEADBEEF;
    if (i == 0)  return 32'hA5A5A5A5;
    return (32'(i) * 32'h01010101) ^ 32'hC3000000;
  endfunction

  // Synchronous-read memory sitting behind the arbiter
  logic [31:0] mem [256];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_write_en) mem[mem_address[9:2]] <= mem_data_in;
      mem_data_out <= mem[mem_address[9:2]];
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] shadow [256];
  logic        lg_m;
  int          since;
  logic        cur_id, cur_we, cur_err;
  logic [31:0] cur_addr, cur_wdata, cur_exp_rdata;
  logic        hs0, hs1, got_rsp, got_err;
  logic [31:0] got_rdata;
  int          we_hi_cnt;
  int          grant_log [$];

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 256);
  endfunction

  task automatic set_req(input logic id, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (id) begin
      req1_if.valid = v; req1_if.we = we; req1_if.addr = a; req1_if.wdata = d;
    end else begin
      req0_if.valid = v; req0_if.we = we; req0_if.addr = a; req0_if.wdata = d;
    end
  endtask

  // One clock: sample and check at negedge, advance the transaction timeline after posedge.
  task automatic cycle();
    logic v0, v1, er0, er1;
    @(negedge clk);
    hs0 = 1'b0; hs1 = 1'b0; got_rsp = 1'b0;
    v0 = req0_if.valid; v1 = req1_if.valid;
    if (mem_write_en) we_hi_cnt++;
    if (!rst_n) begin
      check("rst_ready0", req0_if.ready, 0);
      check("rst_ready1", req1_if.ready, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_we", mem_write_en, 0);
      check("rst_mem_addr", mem_address, 0);
      check("rst_rsp0", req0_if.rsp_valid, 0);
      check("rst_rsp1", req1_if.rsp_valid, 0);
      since = -1;
      lg_m  = 1'b1;
    end else if (since == 1) begin
      check("issue_ready0", req0_if.ready, 0);
      check("issue_ready1", req1_if.ready, 0);
      check("issue_busy", busy, 1);
      check("issue_mem_we", mem_write_en, cur_we && !cur_err);
      check("issue_mem_addr", mem_address, cur_addr);
      if (cur_we && !cur_err) check("issue_mem_din", mem_data_in, cur_wdata);
      check("issue_rsp0", req0_if.rsp_valid, 0);
      check("issue_rsp1", req1_if.rsp_valid, 0);
    end else if (since == 2) begin
      check("resp_valid0", req0_if.rsp_valid, !cur_id);
      check("resp_valid1", req1_if.rsp_valid, cur_id);
      got_rdata = cur_id ? req1_if.rsp_rdata : req0_if.rsp_rdata;
      got_err   = cur_id ? req1_if.rsp_err   : req0_if.rsp_err;
      check("resp_rdata", got_rdata, cur_exp_rdata);
      check("resp_err", got_err, cur_err);
      check("resp_ready0", req0_if.ready, 0);
      check("resp_ready1", req1_if.ready, 0);
      check("resp_mem_we", mem_write_en, 0);
      check("resp_busy", busy, 1);
      got_rsp = 1'b1;
      if (cur_we && !cur_err) shadow[cur_addr[9:2]] = cur_wdata;
    end else begin
      er0 = v0 && (!v1 || lg_m == 1'b1);
      er1 = v1 && (!v0 || lg_m == 1'b0);
      check("idle_ready0", req0_if.ready, er0);
      check("idle_ready1", req1_if.ready, er1);
      check("idle_one_ready", req0_if.ready && req1_if.ready, 0);
      check("idle_busy", busy, 0);
      check("idle_mem_we", mem_write_en, 0);
      check("idle_rsp0", req0_if.rsp_valid, 0);
      check("idle_rsp1", req1_if.rsp_valid, 0);
      hs0 = er0; hs1 = er1;
      if (er0 || er1) begin
        cur_id    = er1;
        cur_we    = er1 ? req1_if.we    : req0_if.we;
        cur_addr  = er1 ? req1_if.addr  : req0_if.addr;
        cur_wdata = er1 ? req1_if.wdata : req0_if.wdata;
        cur_err   = model_err(cur_addr);
        cur_exp_rdata = (!cur_we && !cur_err) ? shadow[cur_addr[9:2]] : 32'h0;
        lg_m  = cur_id;
        grant_log.push_back(int'(cur_id));
        since = 0;
      end
    end
    @(posedge clk);
    #1;
    if (since >= 0) since = (since == 2) ? -1 : since + 1;
  endtask

  task automatic do_txn(input logic id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int we_cnt);
    bit done;
    rdata = '0; err = 1'b0; we_hi_cnt = 0; done = 0;
    set_req(id, 1'b1, we, addr, wdata);
    for (int k = 0; k < 10 && !done; k++) begin
      cycle();
      if ((id && hs1) || (!id && hs0)) done = 1;
    end
    set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!done) begin
      check("hs_timeout", 0, 1);
    end else begin
      done = 0;
      for (int k = 0; k < 6 && !done; k++) begin
        cycle();
        if (got_rsp) begin done = 1; rdata = got_rdata; err = got_err; end
      end
      if (!done) check("rsp_timeout", 0, 1);
    end
    we_cnt = we_hi_cnt;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    if (r == 7) return {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    return 32'h400 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          wc;
    logic        pend [2];
    logic        pwe  [2];
    logic [31:0] pad  [2];
    logic [31:0] pwd  [2];
    int          guard;

    vecs[0] = '{1'b0, 1'b0, 32'h80,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h40,  32'h12345678, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h42,  32'hCAFEF00D, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h12345678, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h400, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 1'b0};

    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    lg_m = 1'b1; since = -1; we_hi_cnt = 0;
    mem_init = 1'b1;
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h80, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h84, 32'h0);

    // Reset with both requesters valid
    repeat (3) cycle();
    mem_init = 1'b0;
    rst_n = 1'b1;

    // Both continuously valid: first grant goes to req0, then strict alternation
    grant_log.delete();
    guard = 0;
    while (grant_log.size() < 6 && guard < 40) begin
      cycle();
      guard++;
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("fair_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      check($sformatf("fair_grant%0d", k), grant_log[k], k % 2);
    guard = 0;
    while (since != -1 && guard < 5) begin cycle(); guard++; end

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, wc);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d_we_cycles", i), wc,
            (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
    end

    // Reset during ISSUE of a write drops the write and its response
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h55AA55AA);
    guard = 0; hs1 = 1'b0;
    while (!hs1 && guard < 10) begin cycle(); guard++; end
    check("midrst_hs", hs1, 1);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, rd, er, wc);
    check("midrst_read_rdata", rd, 32'(init_val(8)));
    check("midrst_read_err", er, 0);
    grant_log.delete();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h14, 32'h0);
    cycle();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("midrst_first_grant_n", grant_log.size(), 1);
    if (grant_log.size() > 0) check("midrst_first_grant", grant_log[0], 0);
    repeat (3) cycle();

    // Randomized traffic against the model
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int id = 0; id < 2; id++) begin
        if (!pend[id] && $urandom_range(0, 1) == 1) begin
          pend[id] = 1'b1;
          pwe[id]  = 1'($urandom_range(0, 1));
          pad[id]  = rand_addr();
          pwd[id]  = $urandom();
        end
        set_req(1'(id), pend[id], pend[id] ? pwe[id] : 1'b0,
                pend[id] ? pad[id] : 32'h0, pend[id] ? pwd[id] : 32'h0);
      end
      cycle();
      if (hs0) pend[0] = 1'b0;
      if (hs1) pend[1] = 1'b0;
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
